// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
//
// Bank of NumRegs registers, each DataBits wide, for the 8-bit computer.
// One write port applies LOAD / INC / DEC / CLR to the addressed register.
// Two independent combinational read ports are available. When Bypass=1, a
// read of the register being written returns the value that register will
// take at the next edge. Registered zero/carry flags describe the last
// executed write.
//
// Parameters
//   DataBits  width of every register and data port
//   NumRegs   number of registers (2..256)
//   AddrBits  address width, 2**AddrBits >= NumRegs
//   Bypass    1: write-to-read forwarding, 0: reads return stored value
//
// Ports
//   clock      rising-edge clock
//   bReset     asynchronous active-low reset
//   wr_enable  execute wr_op on wr_addr at the rising edge
//   wr_addr    write target
//   wr_op      00 LOAD, 01 INC, 10 DEC, 11 CLR
//   wr_data    LOAD operand
//   rd_addr_a  read port A address   rd_data_a  read port A data
//   rd_addr_b  read port B address   rd_data_b  read port B data
//   zero       last executed write produced 0
//   carry      carry/borrow of last executed write
// ---------------------------------------------------------------------------
module register_file #(
  parameter int DataBits = 8,
  parameter int NumRegs  = 4,
  parameter int AddrBits = 2,
  parameter bit Bypass   = 1'b1
) (
  input  logic                clock,
  input  logic                bReset,
  input  logic                wr_enable,
  input  logic [AddrBits-1:0] wr_addr,
  input  logic [1:0]          wr_op,
  input  logic [DataBits-1:0] wr_data,
  input  logic [AddrBits-1:0] rd_addr_a,
  output logic [DataBits-1:0] rd_data_a,
  input  logic [AddrBits-1:0] rd_addr_b,
  output logic [DataBits-1:0] rd_data_b,
  output logic                zero,
  output logic                carry
);

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_INC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_CLR  = 2'b11
  } wr_op_e;

  // One extra bit so NumRegs = 2**AddrBits is representable.
  localparam logic [AddrBits:0] NumRegsW = (AddrBits + 1)'(NumRegs);

  logic [DataBits-1:0] regs [NumRegs];

  wr_op_e              op;
  logic                wr_in_range;
  logic                wr_fire;
  logic [DataBits-1:0] cur_val;
  logic [DataBits-1:0] stored_a;
  logic [DataBits-1:0] stored_b;
  logic [DataBits:0]   sum;
  logic [DataBits-1:0] wr_result;
  logic                wr_carry;

  assign op          = wr_op_e'(wr_op);
  assign wr_in_range = ({1'b0, wr_addr} < NumRegsW);
  // A write held during reset must neither land nor be forwarded.
  assign wr_fire     = bReset & wr_enable & wr_in_range;

  // Address decode as a compare loop: an address with no matching
  // register leaves the default 0, so the out-of-range reads of a
  // non-power-of-two bank need no separate handling.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    cur_val  = '0;
    stored_a = '0;
    stored_b = '0;
    for (int i = 0; i < NumRegs; i++) begin
      if (wr_addr   == AddrBits'(i)) cur_val  = regs[i];
      if (rd_addr_a == AddrBits'(i)) stored_a = regs[i];
      if (rd_addr_b == AddrBits'(i)) stored_b = regs[i];
    end
  end

  // One extra bit on the adder: MSB is the carry on INC and the borrow
  // on DEC (0 - 1 sets every bit, including the MSB).
  always_comb begin
    sum = '0;
    case (op)
      OP_LOAD: sum = {1'b0, wr_data};
      OP_INC:  sum = {1'b0, cur_val} + (DataBits + 1)'(1);
      OP_DEC:  sum = {1'b0, cur_val} - (DataBits + 1)'(1);
      OP_CLR:  sum = '0;
      default: sum = '0;
    endcase
  end

  assign wr_result = sum[DataBits-1:0];
  assign wr_carry  = sum[DataBits];

  assign rd_data_a = (Bypass && wr_fire && (rd_addr_a == wr_addr)) ? wr_result : stored_a;
  assign rd_data_b = (Bypass && wr_fire && (rd_addr_b == wr_addr)) ? wr_result : stored_b;

  // NOTE: the bank is architectural state that must read 0 straight after
  // reset, so every register sits on the asynchronous reset rather than
  // being left as uninitialised RAM.
  always_ff @(posedge clock or negedge bReset) begin
    if (!bReset) begin
      for (int i = 0; i < NumRegs; i++) regs[i] <= '0;
      zero  <= 1'b0;
      carry <= 1'b0;
    end else if (wr_fire) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      for (int i = 0; i < NumRegs; i++) begin
        if (wr_addr == AddrBits'(i)) regs[i] <= wr_result;
      end
      zero  <= (wr_result == '0);
      carry <= wr_carry;
    end
  end

endmodule

// File: tb/tb_register_file.sv
// ---------------------------------------------------------------------------
// tb_register_file
//
// Drives three register_file instances with identical stimulus:
//   cfg0: NumRegs=4, Bypass=1
//   cfg1: NumRegs=4, Bypass=0
//   cfg2: NumRegs=3, Bypass=1
// For every stimulus cycle, the expected reads and flags come from an
// array-based model and are queued. A monitor on the falling edge pops one
// entry per cycle and compares it against all three instances.
// ---------------------------------------------------------------------------
module tb_register_file;

  localparam int NCFG = 3;

  logic       clock = 1'b0;
  logic       bReset;
  logic       wr_enable;
  logic [1:0] wr_addr;
  logic [1:0] wr_op;
  logic [7:0] wr_data;
  logic [1:0] rd_addr_a;
  logic [1:0] rd_addr_b;

  logic [7:0] rda [NCFG];
  logic [7:0] rdb [NCFG];
  logic       zf  [NCFG];
  logic       cf  [NCFG];

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  register_file #(.DataBits(8), .NumRegs(4), .AddrBits(2), .Bypass(1'b1)) dut_byp (
    .clock(clock), .bReset(bReset), .wr_enable(wr_enable), .wr_addr(wr_addr),
    .wr_op(wr_op), .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_data_a(rda[0]),
    .rd_addr_b(rd_addr_b), .rd_data_b(rdb[0]), .zero(zf[0]), .carry(cf[0]));

  register_file #(.DataBits(8), .NumRegs(4), .AddrBits(2), .Bypass(1'b0)) dut_nobyp (
    .clock(clock), .bReset(bReset), .wr_enable(wr_enable), .wr_addr(wr_addr),
    .wr_op(wr_op), .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_data_a(rda[1]),
    .rd_addr_b(rd_addr_b), .rd_data_b(rdb[1]), .zero(zf[1]), .carry(cf[1]));

  register_file #(.DataBits(8), .NumRegs(3), .AddrBits(2), .Bypass(1'b1)) dut_three (
    .clock(clock), .bReset(bReset), .wr_enable(wr_enable), .wr_addr(wr_addr),
    .wr_op(wr_op), .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_data_a(rda[2]),
    .rd_addr_b(rd_addr_b), .rd_data_b(rdb[2]), .zero(zf[2]), .carry(cf[2]));

  // ---------------- reference model ----------------
  int m_regs  [NCFG][4];
  bit m_zero  [NCFG];
  bit m_carry [NCFG];

  function automatic int cfg_nregs(int k);
    return (k == 2) ? 3 : 4;
  endfunction

  function automatic bit cfg_bypass(int k);
    return (k != 1);
  endfunction

  function automatic int op_result(int old, int op, int data);
    case (op)
      0:       return data;
      1:       return (old + 1) % 256;
      2:       return (old + 255) % 256;
      default: return 0;
    endcase
  endfunction

  function automatic bit op_carry(int old, int op);
    if (op == 1) return (old == 255);
    if (op == 2) return (old == 0);
    return 1'b0;
  endfunction

  function automatic int model_read(int k, int addr);
    int wa;
    wa = int'(wr_addr);
    if (bReset && wr_enable && cfg_bypass(k) && wa < cfg_nregs(k) && addr == wa)
      return op_result(m_regs[k][wa], int'(wr_op), int'(wr_data));
    if (addr >= cfg_nregs(k)) return 0;
    return m_regs[k][addr];
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NCFG; k++) begin
      for (int r = 0; r < 4; r++) m_regs[k][r] = 0;
      m_zero[k]  = 1'b0;
      m_carry[k] = 1'b0;
    end
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    string                  name;
    logic [NCFG-1:0][7:0]   a;
    logic [NCFG-1:0][7:0]   b;
    logic [NCFG-1:0]        z;
    logic [NCFG-1:0]        c;
  } exp_t;

  exp_t sb [$];

  task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, actual, expected);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      for (int k = 0; k < NCFG; k++) begin
        check($sformatf("%s.cfg%0d.rd_a", e.name, k), rda[k], e.a[k]);
        check($sformatf("%s.cfg%0d.rd_b", e.name, k), rdb[k], e.b[k]);
        check($sformatf("%s.cfg%0d.zero", e.name, k), 8'(zf[k]), 8'(e.z[k]));
        check($sformatf("%s.cfg%0d.carry", e.name, k), 8'(cf[k]), 8'(e.c[k]));
      end
    end
  end

  // Called one time unit after a rising edge: drive inputs, queue the
  // expected view for this cycle, then advance the model across the edge.
  task automatic do_cycle(input string name, input bit en, input int addr, input int op,
                          input int data, input int ra, input int rb);
    exp_t e;
    int   old;
    wr_enable = en;
    wr_addr   = 2'(addr);
    wr_op     = 2'(op);
    wr_data   = 8'(data);
    rd_addr_a = 2'(ra);
    rd_addr_b = 2'(rb);
    e.name = name;
    for (int k = 0; k < NCFG; k++) begin
      e.a[k] = 8'(model_read(k, ra));
      e.b[k] = 8'(model_read(k, rb));
      e.z[k] = m_zero[k];
      e.c[k] = m_carry[k];
    end
    sb.push_back(e);
    @(posedge clock);
    if (bReset && en) begin
      for (int k = 0; k < NCFG; k++) begin
        if (addr < cfg_nregs(k)) begin
          old            = m_regs[k][addr];
          m_regs[k][addr] = op_result(old, op, data);
          m_zero[k]      = (m_regs[k][addr] == 0);
          m_carry[k]     = op_carry(old, op);
        end
      end
    end
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bReset    = 1'b0;
    wr_enable = 1'b0;
    wr_addr   = '0;
    wr_op     = '0;
    wr_data   = '0;
    rd_addr_a = '0;
    rd_addr_b = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    bReset = 1'b1;

    do_cycle("rst_r0r1", 0, 0, 0, 0, 0, 1);
    do_cycle("rst_r2r3", 0, 0, 0, 0, 2, 3);

    do_cycle("ld_r1",    1, 1, 0, 'hA5, 1, 2);
    do_cycle("ld_r2",    1, 2, 0, 'h3C, 1, 2);
    do_cycle("rd_r1r2",  0, 0, 0, 0,    1, 2);
    do_cycle("ld0_r3",   1, 3, 0, 'h00, 3, 0);
    do_cycle("flags_r3", 0, 0, 0, 0,    3, 1);

    do_cycle("ld_fe_r0", 1, 0, 0, 'hFE, 0, 1);
    do_cycle("inc1_r0",  1, 0, 1, 'h11, 0, 1);
    do_cycle("inc2_r0",  1, 0, 1, 'h22, 0, 1);
    do_cycle("dec_r0",   1, 0, 2, 'h33, 0, 1);
    do_cycle("after_dec",0, 0, 0, 0,    0, 1);

    do_cycle("byp_ld_r2",1, 2, 0, 'h77, 2, 1);
    do_cycle("rd_r2",    0, 0, 0, 0,    2, 1);

    do_cycle("oob_wr3",  1, 3, 0, 'h55, 3, 2);
    do_cycle("oob_rd3",  0, 0, 0, 0,    3, 0);

    for (int i = 0; i < 20; i++)
      do_cycle("hold", 0, $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 255), $urandom_range(0, 3), $urandom_range(0, 3));

    do_cycle("clr_r1",   1, 1, 3, 'h5A, 1, 0);
    do_cycle("after_clr",0, 0, 0, 0,    1, 0);

    for (int i = 0; i < 300; i++)
      do_cycle("rand", ($urandom_range(0, 3) != 0), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 255), $urandom_range(0, 3), $urandom_range(0, 3));

    // Reset asserted mid-cycle while registers hold data.
    do_cycle("pre_rst",  1, 1, 0, 'hC3, 1, 2);
    wr_enable = 1'b1;
    wr_addr   = 2'd0;
    wr_op     = 2'd0;
    wr_data   = 8'h99;
    rd_addr_a = 2'd1;
    rd_addr_b = 2'd2;
    bReset    = 1'b0;
    #1;
    for (int k = 0; k < NCFG; k++) begin
      check($sformatf("async_rst.cfg%0d.rd_a", k), rda[k], 8'h00);
      check($sformatf("async_rst.cfg%0d.rd_b", k), rdb[k], 8'h00);
      check($sformatf("async_rst.cfg%0d.zero", k), 8'(zf[k]), 8'h00);
      check($sformatf("async_rst.cfg%0d.carry", k), 8'(cf[k]), 8'h00);
    end
    model_reset();
    do_cycle("rst_held", 1, 0, 0, 'h99, 1, 2);
    bReset = 1'b1;
    do_cycle("post_rst_ld", 1, 0, 0, 'h12, 0, 1);
    do_cycle("post_rst_rd", 0, 0, 0, 0,    0, 1);

    @(negedge clock);
    #1;
    check("sb_drained", 8'(sb.size()), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
